// File: rtl/i2s_rx_pkg.sv
// ---------------------------------------------------------------------------
// i2s_rx_pkg
// Shared types and constants for the I2S receive deserializer.
//   rx_state_t      : capture FSM states (IDLE, SYNC, LEFT, RIGHT)
//   RX_SYNC_STAGES  : depth of the input synchronizer chains
//   RX_CNT_W        : width of the accepted-pair counter output
// ---------------------------------------------------------------------------
package i2s_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } rx_state_t;

    localparam int RX_SYNC_STAGES = 2;
    localparam int RX_CNT_W       = 16;

endpackage

// File: rtl/fifo_buffer.sv
// ---------------------------------------------------------------------------
// fifo_buffer
// Synchronous FIFO, 2**W entries of B bits, first-word-fall-through read port.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   wr, w_data : write request and data
//   rd         : read request (removes the head entry)
//   r_data     : head entry, valid while empty = 0
//   empty/full : occupancy flags
// A read and a write in the same cycle are both honoured even when full:
// the read frees the slot the write then occupies.
// ---------------------------------------------------------------------------
module fifo_buffer #(
    parameter int B = 8,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rd,
    input  logic         wr,
    input  logic [B-1:0] w_data,
    output logic         empty,
    output logic         full,
    output logic [B-1:0] r_data
);

    logic [B-1:0] mem_q [2**W];

    logic [W-1:0] wr_ptr_q, wr_ptr_d;
    logic [W-1:0] rd_ptr_q, rd_ptr_d;
    logic         full_q, full_d;
    logic         empty_q, empty_d;

    logic         do_rd;
    logic         do_wr;
    logic [W-1:0] wr_ptr_succ;
    logic [W-1:0] rd_ptr_succ;

    assign do_rd       = rd & ~empty_q;
    assign do_wr       = wr & (~full_q | do_rd);
    assign wr_ptr_succ = wr_ptr_q + W'(1);
    assign rd_ptr_succ = rd_ptr_q + W'(1);

    // Storage has no reset; only the pointers and flags define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= w_data;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        full_d   = full_q;
        empty_d  = empty_q;
        case ({do_wr, do_rd})
            2'b01: begin
                rd_ptr_d = rd_ptr_succ;
                full_d   = 1'b0;
                empty_d  = (rd_ptr_succ == wr_ptr_q);
            end
            2'b10: begin
                wr_ptr_d = wr_ptr_succ;
                empty_d  = 1'b0;
                full_d   = (wr_ptr_succ == rd_ptr_q);
            end
            2'b11: begin
                wr_ptr_d = wr_ptr_succ;
                rd_ptr_d = rd_ptr_succ;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign empty  = empty_q;
    assign full   = full_q;
    assign r_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/i2s_rx_deserializer.sv
// ---------------------------------------------------------------------------
// i2s_rx_deserializer
// I2S receiver: oversamples TCLK/WS/TD in the i_clk domain, deserializes
// MSB-first left/right words and queues them as pairs behind a valid/ready
// stream.
// Ports:
//   i_clk, i_rst_n        : system clock (>= 4x TCLK), async active-low reset
//   i_enable              : capture enable
//   i_clr_ovr             : clears the sticky overrun flag
//   i_tclk, i_ws, i_td    : I2S bit clock, word select (0=left), serial data
//   o_valid, i_ready      : pair stream handshake (pop on o_valid & i_ready)
//   o_data_left/right     : pair at the FIFO head
//   o_overrun             : sticky, a completed pair was dropped (FIFO full)
//   o_frame_err           : one-cycle pulse, a word ended with < DATA_W bits
//   o_frame_cnt           : accepted pair count
// Build option I2S_RX_FRAME_CNT_EN: when defined, o_frame_cnt counts accepted
// pushes (wraps, cleared only by reset); otherwise it is constant zero.
// ---------------------------------------------------------------------------
module i2s_rx_deserializer
    import i2s_rx_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int FIFO_AW = 2
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_enable,
    input  logic                i_clr_ovr,
    input  logic                i_tclk,
    input  logic                i_ws,
    input  logic                i_td,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [DATA_W-1:0]   o_data_left,
    output logic [DATA_W-1:0]   o_data_right,
    output logic                o_overrun,
    output logic                o_frame_err,
    output logic [RX_CNT_W-1:0] o_frame_cnt
);

    localparam int                   BIT_CNT_W   = $clog2(DATA_W + 1);
    localparam logic [BIT_CNT_W-1:0] BIT_CNT_MAX = BIT_CNT_W'(DATA_W);

    // Input synchronizers
    logic [RX_SYNC_STAGES-1:0] tclk_sync_q, tclk_sync_d;
    logic [RX_SYNC_STAGES-1:0] ws_sync_q, ws_sync_d;
    logic [RX_SYNC_STAGES-1:0] td_sync_q, td_sync_d;
    logic                      tclk_s;
    logic                      ws_s;
    logic                      td_s;

    // Bit-event tracking
    logic tclk_prev_q, tclk_prev_d;
    logic ws_prev_q, ws_prev_d;
    logic bit_event;
    logic word_end;

    // Deserializer and FSM
    rx_state_t               state_q, state_d;
    logic [DATA_W-1:0]       shift_q, shift_d;
    logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]       left_q, left_d;
    logic [2*DATA_W-1:0]     pair_q, pair_d;
    logic                    push_q, push_d;
    logic                    frame_err_q, frame_err_d;
    logic                    overrun_q, overrun_d;
    logic                    cnt_full;
    logic [DATA_W-1:0]       word_next;
    logic [BIT_CNT_W-1:0]    bit_cnt_next;
    logic                    word_short;

    // FIFO interface
    logic                    fifo_empty;
    logic                    fifo_full;
    logic [2*DATA_W-1:0]     fifo_rdata;
    logic                    pop;

    // Shift each pin into its own synchronizer chain; all three chains have
    // equal depth so ws/td stay aligned with the tclk edge that samples them.
    always_comb begin
        tclk_sync_d = {tclk_sync_q[RX_SYNC_STAGES-2:0], i_tclk};
        ws_sync_d   = {ws_sync_q[RX_SYNC_STAGES-2:0], i_ws};
        td_sync_d   = {td_sync_q[RX_SYNC_STAGES-2:0], i_td};
    end

    assign tclk_s    = tclk_sync_q[RX_SYNC_STAGES-1];
    assign ws_s      = ws_sync_q[RX_SYNC_STAGES-1];
    assign td_s      = td_sync_q[RX_SYNC_STAGES-1];
    assign bit_event = tclk_s & ~tclk_prev_q;

    // The bit sampled now belongs to the channel WS selected at the previous
    // event; a WS change marks this bit as the LSB of the word that ends.
    assign word_end = bit_event & (ws_s != ws_prev_q);

    // Once DATA_W bits are held, later bits of the same word are discarded.
    assign cnt_full     = (bit_cnt_q == BIT_CNT_MAX);
    assign word_next    = cnt_full ? shift_q : {shift_q[DATA_W-2:0], td_s};
    assign bit_cnt_next = cnt_full ? bit_cnt_q : bit_cnt_q + BIT_CNT_W'(1);
    assign word_short   = (bit_cnt_next < BIT_CNT_MAX);

    assign o_valid = ~fifo_empty;
    assign pop     = ~fifo_empty & i_ready;

    // Next-state: bit shifting runs in every state so the counter is always
    // aligned to word boundaries; only LEFT/RIGHT act on the completed words.
    always_comb begin
        state_d     = state_q;
        tclk_prev_d = tclk_s;
        ws_prev_d   = ws_prev_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        left_d      = left_q;
        pair_d      = pair_q;
        push_d      = 1'b0;
        frame_err_d = 1'b0;

        if (bit_event) begin
            ws_prev_d = ws_s;
            if (word_end) begin
                shift_d   = '0;
                bit_cnt_d = '0;
            end else begin
                shift_d   = word_next;
                bit_cnt_d = bit_cnt_next;
            end
        end

        case (state_q)
            IDLE: begin
                if (i_enable) begin
                    state_d = SYNC;
                end
            end
            SYNC: begin
                if (word_end && ws_prev_q) begin
                    state_d = LEFT;
                end
            end
            LEFT: begin
                if (word_end) begin
                    if (word_short) begin
                        frame_err_d = 1'b1;
                        state_d     = SYNC;
                    end else begin
                        left_d  = word_next;
                        state_d = RIGHT;
                    end
                end
            end
            RIGHT: begin
                if (word_end) begin
                    if (word_short) begin
                        frame_err_d = 1'b1;
                        state_d     = SYNC;
                    end else begin
                        pair_d  = {left_q, word_next};
                        push_d  = 1'b1;
                        state_d = LEFT;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Disable abandons any partial word; queued pairs are untouched.
        if (!i_enable) begin
            state_d     = IDLE;
            push_d      = 1'b0;
            frame_err_d = 1'b0;
        end
    end

    // Overrun: a push that finds the FIFO full with no simultaneous pop is
    // dropped. Setting takes priority over a coinciding clear.
    always_comb begin
        overrun_d = overrun_q;
        if (push_q && fifo_full && !pop) begin
            overrun_d = 1'b1;
        end else if (i_clr_ovr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tclk_sync_q <= '0;
            ws_sync_q   <= '0;
            td_sync_q   <= '0;
            tclk_prev_q <= 1'b0;
            ws_prev_q   <= 1'b0;
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            left_q      <= '0;
            pair_q      <= '0;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            tclk_sync_q <= tclk_sync_d;
            ws_sync_q   <= ws_sync_d;
            td_sync_q   <= td_sync_d;
            tclk_prev_q <= tclk_prev_d;
            ws_prev_q   <= ws_prev_d;
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            left_q      <= left_d;
            pair_q      <= pair_d;
            push_q      <= push_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    fifo_buffer #(
        .B (2 * DATA_W),
        .W (FIFO_AW)
    ) u_pair_fifo (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .rd     (pop),
        .wr     (push_q),
        .w_data (pair_q),
        .empty  (fifo_empty),
        .full   (fifo_full),
        .r_data (fifo_rdata)
    );

    assign o_data_left  = fifo_rdata[2*DATA_W-1:DATA_W];
    assign o_data_right = fifo_rdata[DATA_W-1:0];
    assign o_overrun    = overrun_q;
    assign o_frame_err  = frame_err_q;

`ifdef I2S_RX_FRAME_CNT_EN
    logic                push_accept;
    logic [RX_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    // A push is accepted when there is room, counting room freed by a pop.
    assign push_accept = push_q & (~fifo_full | pop);

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (push_accept) begin
            frame_cnt_d = frame_cnt_q + RX_CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign o_frame_cnt = frame_cnt_q;
`else
    assign o_frame_cnt = '0;
`endif

endmodule
